fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end that feeds the decode/control stage. Owns the program counter and drives the instruction-memory address. Delivers each fetched word, with its PC and PC+4, through a 2-entry valid/ready queue. Accepts redirects (jumps and branches resolved downstream), flushes wrong-path entries on a redirect, and stops fetching on the all-zero terminator word.

## Interface
Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  current PC, driven combinationally from the PC register.
- imem_data  in  32  instruction word at imem_addr; combinational, valid in the same cycle.
- redirect_valid  in  1  downstream requests a PC change.
- redirect_target  in  32  new PC; bits [1:0] ignored and treated as 00.
- out_valid  out  1  head queue entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_inst  out  32  head entry instruction.
- out_pc  out  32  head entry PC.
- out_pc_plus4  out  32  head entry PC+4.
- halted  out  1  fetch stopped on a zero word.

## Operation
- State: pc (32), queue of 2 entries {inst, pc}, count (0..2), halted.
- pop = out_valid && out_ready.
- fetch_en = !halted && !redirect_valid && (count < 2 || pop).
- Fetch when fetch_en and imem_data != 0:
  - push {imem_data, pc}.
  - pc <= pc + 4 (mod 2^32; wraps from FFFFFFFC to 00000000).
- Fetch when fetch_en and imem_data == 0:
  - no push, pc holds, halted <= 1.
- No fetch: pc holds.
- Queue is FIFO. The head drives out_*, and out_pc_plus4 = out_pc + 4.
- Push and pop in the same cycle keep count unchanged and preserve order.
- Redirect (redirect_valid=1): highest priority below reset.
  - queue flushed (count <= 0).
  - pc <= {redirect_target[31:2], 2'b00}.
  - halted <= 0.
  - The imem word in that cycle is discarded.
  - A same-cycle pop is still a completed handoff.
- halted is sticky until redirect or reset. Queued entries still drain while halted.
- Reset: pc=RESET_PC, count=0, halted=0, queue contents=0. As a result out_valid=0, out_inst=0, out_pc=0, out_pc_plus4=4.
- Reset mid-operation discards all queued entries and any pending redirect.

## Timing
- imem_addr = pc with zero latency; a PC update is visible the cycle after the edge.
- Fetch-to-output latency: a word fetched in cycle N is on out_* in cycle N+1, if it reaches the head.
- Throughput: 1 instruction/cycle with out_ready held high.
- Backpressure:
  - with out_ready=0, at most 2 entries are buffered.
  - pc advances 2 words past the head, then holds.
  - no word is lost or duplicated.
- out_valid and out_* must hold stable while out_valid && !out_ready.
- Redirect latency:
  - redirect in cycle N; imem_addr=target in N+1; target instruction on out_* in N+2.
  - out_valid=0 in N+1.
- No delay slot: the word after a jump is never delivered unless it is the redirect target.

## Configuration
- FETCH_JUMP_PREDECODE_EN defined:
  - on a successful fetch where imem_data[31:26] is 6'h02 (J) or 6'h03 (JAL), the word is still pushed.
  - pc <= {pc_plus4[31:28], imem_data[25:0], 2'b00} instead of pc+4.
  - the jump target is fetched the next cycle, with no downstream redirect needed.
  - an external redirect in the same cycle wins.
- Not defined: fetch always advances sequentially; all PC changes come only from redirect_valid.

## Test plan
- Reset, then release with memory at 00400000..0C all nonzero and out_ready=1:
  - cycle 1 after reset: out_pc=00400000.
  - following cycles: out_pc = 00400004, 00400008, 0040000C on consecutive cycles, with out_valid held at 1.
- out_ready=0 for 5 cycles after reset:
  - count=2 and imem_addr holds at 00400008.
  - after out_ready=1: 00400000, 00400004, 00400008 are delivered in order, each exactly once.
- Word at 00400008 = 0:
  - 00400000 and 00400004 are delivered.
  - halted=1 from the cycle after the fetch of 00400008.
  - imem_addr stays 00400008 and out_valid=0 after the drain.
- Redirect while 2 entries are queued, target 00400023:
  - queue flushed and out_valid=0 the next cycle.
  - imem_addr=00400020.
  - out_pc=00400020 two cycles after the redirect.
  - halted cleared if it was set.
- With FETCH_JUMP_PREDECODE_EN, word 08100010 (J) at 00400000:
  - out_pc sequence is 00400000 then 00400040.
  - 00400004 is never delivered.
  - without the macro, 00400004 follows instead.
- Assert reset for one cycle mid-stream with a redirect on the same cycle:
  - out_valid=0 and halted=0.
  - imem_addr=00400000 the next cycle, and the redirect is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, drives imem_addr and buffers fetched
// words in a 2-entry valid/ready queue. Optional macro: FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        halted_q, halted_d;
  logic [31:0] inst0_q, inst0_d, pc0_q, pc0_d;
  logic [31:0] inst1_q, inst1_d, pc1_q, pc1_d;

  logic        pop_s;
  logic        fetch_en_s;
  logic        push_s;
  logic        is_jump_s;
  logic [31:0] seq_pc_s;
  logic [31:0] fetch_next_pc_s;

  // Handshake, fetch qualification and the PC that follows a successful fetch.
  always_comb begin
    pop_s      = (count_q != 2'd0) && out_ready;
    fetch_en_s = !halted_q && !redirect_valid && ((count_q < 2'd2) || pop_s);
    push_s     = fetch_en_s && (imem_data != 32'd0);
    seq_pc_s   = pc_q + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    is_jump_s  = (imem_data[31:26] == 6'h02) || (imem_data[31:26] == 6'h03);
`else
    is_jump_s  = 1'b0;
`endif
    if (is_jump_s) begin
      fetch_next_pc_s = {seq_pc_s[31:28], imem_data[25:0], 2'b00};
    end else begin
      fetch_next_pc_s = seq_pc_s;
    end
  end

  // Next-state for PC, halt flag and the FIFO (entry 0 is always the head).
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    halted_d = halted_q;
    inst0_d  = inst0_q;
    pc0_d    = pc0_q;
    inst1_d  = inst1_q;
    pc1_d    = pc1_q;
    if (redirect_valid) begin
      // A same-cycle pop still completes; the flush drops everything else.
      count_d  = 2'd0;
      pc_d     = {redirect_target[31:2], 2'b00};
      halted_d = 1'b0;
    end else begin
      if (push_s) begin
        pc_d = fetch_next_pc_s;
      end else if (fetch_en_s) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q;
      end
      case ({push_s, pop_s})
        2'b10: begin
          case (count_q)
            2'd0: begin
              inst0_d = imem_data;
              pc0_d   = pc_q;
              count_d = 2'd1;
            end
            2'd1: begin
              inst1_d = imem_data;
              pc1_d   = pc_q;
              count_d = 2'd2;
            end
            default: count_d = count_q;
          endcase
        end
        2'b01: begin
          inst0_d = inst1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            inst0_d = imem_data;
            pc0_d   = pc_q;
          end else begin
            inst0_d = inst1_q;
            pc0_d   = pc1_q;
            inst1_d = imem_data;
            pc1_d   = pc_q;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      halted_q <= 1'b0;
      inst0_q  <= 32'd0;
      pc0_q    <= 32'd0;
      inst1_q  <= 32'd0;
      pc1_q    <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      inst0_q  <= inst0_d;
      pc0_q    <= pc0_d;
      inst1_q  <= inst1_d;
      pc1_q    <= pc1_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_inst     = inst0_q;
  assign out_pc       = pc0_q;
  assign out_pc_plus4 = pc0_q + 32'd4;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expected values are hand-derived.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];
  logic [31:0] off_s;

  fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .halted(halted)
  );

  always #5 clock = ~clock;

  // Instruction memory model: 64 words at 0x00400000, fixed nonzero word elsewhere.
  always_comb begin
    off_s = imem_addr - 32'h0040_0000;
    if (off_s < 32'd256) imem_data = mem[off_s[7:2]];
    else                 imem_data = 32'h2400_0001;
  end

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | i;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0; out_ready = ready;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    init_mem();
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (out_pc_plus4 !== 32'd4) begin failures++; $display("FAIL reset_pc4 got=%h exp=4", out_pc_plus4); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL reset_addr got=%h exp=00400000", imem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    init_mem();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'h0040_0000 + 32'(i * 4);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin failures++; $display("FAIL stream_pc%0d got=%h v=%0b exp=%h", i, out_pc, out_valid, exp_pc); end
      checks++; if (out_inst !== (32'h2400_0000 | 32'(i)) || out_pc_plus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL stream_inst%0d got=%h/%h", i, out_inst, out_pc_plus4); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    init_mem();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_addr !== 32'h0040_0008) begin failures++; $display("FAIL bp_addr got=%h exp=00400008", imem_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000) begin failures++; $display("FAIL bp_head got=%h v=%0b exp=00400000", out_pc, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h0040_0000 + 32'(i * 4);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin failures++; $display("FAIL bp_drain%0d got=%h exp=%h", i, out_pc, exp_pc); end
      step();
    end
  endtask

  task automatic test_halt();
    init_mem();
    mem[2] = 32'd0;
    do_reset(1'b1);
    step();
    checks++; if (out_pc !== 32'h0040_0000 || halted !== 1'b0) begin failures++; $display("FAIL halt_first got=%h h=%0b", out_pc, halted); end
    step();
    checks++; if (out_pc !== 32'h0040_0004 || out_valid !== 1'b1) begin failures++; $display("FAIL halt_second got=%h v=%0b", out_pc, out_valid); end
    step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%0b exp=1", halted); end
    step(); step();
    checks++; if (imem_addr !== 32'h0040_0008 || out_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold addr=%h v=%0b h=%0b", imem_addr, out_valid, halted); end
    redirect_valid = 1'b1; redirect_target = 32'h0040_0023;
    step();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 32'h0040_0020 || out_valid !== 1'b0) begin failures++; $display("FAIL halt_redirect h=%0b addr=%h v=%0b", halted, imem_addr, out_valid); end
    step();
    checks++; if (out_pc !== 32'h0040_0020 || out_valid !== 1'b1) begin failures++; $display("FAIL halt_resume got=%h v=%0b", out_pc, out_valid); end
  endtask

  task automatic test_redirect();
    init_mem();
    do_reset(1'b0);
    step(); step();
    checks++; if (imem_addr !== 32'h0040_0008 || out_pc !== 32'h0040_0000) begin failures++; $display("FAIL redir_full addr=%h pc=%h", imem_addr, out_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h0040_0023;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0020) begin failures++; $display("FAIL redir_flush v=%0b addr=%h", out_valid, imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0020 || out_inst !== 32'h2400_0008) begin failures++; $display("FAIL redir_target pc=%h inst=%h", out_pc, out_inst); end
    checks++; if (imem_addr !== 32'h0040_0024) begin failures++; $display("FAIL redir_next got=%h exp=00400024", imem_addr); end
  endtask

  task automatic test_wrap();
    init_mem();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    step();
    checks++; if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'd0 || imem_addr !== 32'd0) begin failures++; $display("FAIL wrap pc=%h pc4=%h addr=%h", out_pc, out_pc_plus4, imem_addr); end
  endtask

  task automatic test_jump();
    logic [31:0] exp_pc;
    init_mem();
    mem[0] = 32'h0810_0010;
    do_reset(1'b1);
    step();
    checks++; if (out_pc !== 32'h0040_0000 || out_inst !== 32'h0810_0010) begin failures++; $display("FAIL jump_word pc=%h inst=%h", out_pc, out_inst); end
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_pc = 32'h0040_0040;
`else
    exp_pc = 32'h0040_0004;
`endif
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin failures++; $display("FAIL jump_next got=%h exp=%h", out_pc, exp_pc); end
  endtask

  task automatic test_reset_mid();
    init_mem();
    do_reset(1'b1);
    step(); step(); step();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL rstmid v=%0b h=%0b addr=%h", out_valid, halted, imem_addr); end
    step();
    checks++; if (out_pc !== 32'h0040_0000 || out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_resume got=%h v=%0b", out_pc, out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_redirect();
    test_wrap();
    test_jump();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
